echo_processor: RTL
===================

// Module: echo_processor
// PURPOSE
// Parametrised echo engine for the audio path: ADC samples in, DAC codes out. Stores samples
// in an on-chip circular buffer and mixes a delayed, attenuated copy back into the signal.
// Delay and gain are set at run time. The mode input selects a single echo (feed-forward) or
// a decaying multi-echo (feedback). The result saturates instead of wrapping.
// PARAMETERS
// W          10      sample width (bits), data_in/data_out/buffer word
// AW         13      buffer address width; DEPTH = 2**AW words
// ADC_OFFSET 'h181   ADC code for zero signal, removed at input (W bits)
// DAC_OFFSET 'h200   DAC code for zero signal, added at output (W bits)
// PORTS
// sysclk      in   1    system clock, all logic on posedge
// reset       in   1    synchronous, active-high
// data_in     in   W    raw ADC code, valid while data_valid high
// data_valid  in   1    ADC sample flag; each rising edge = one new sample
// delay       in   AW   echo delay in samples; 0 treated as 1
// gain_shift  in   2    echo attenuation: 0 = echo muted, n = echo >>> n (n=1..3)
// mode        in   1    0 = single echo (buffer stores x), 1 = feedback (buffer stores y)
// data_out    out  W    DAC code, registered, held between samples
// out_valid   out  1    one-cycle pulse when data_out updates
// BEHAVIOUR
// - Reset: state=IDLE, wr_ptr=0, fill=0, dv_q=0, data_out=DAC_OFFSET, out_valid=0.
//   Buffer RAM is not cleared; fill masks stale contents.
// - Strobe: strobe = data_valid & ~dv_q, where dv_q is data_valid registered.
//   Exactly one strobe per high pulse, whatever the pulse length.
// - FSM IDLE -> RD -> CALC -> IDLE:
//   IDLE: on strobe, x_reg <= data_in - ADC_OFFSET (W-bit 2's complement), present
//     rd_addr = wr_ptr - d (mod DEPTH), d = max(delay,1); latch d_reg, gain_reg, mode_reg; go RD.
//   RD: sync RAM read completes; go CALC.
//   CALC: compute y, write buffer[wr_ptr], update data_out, pulse out_valid, wr_ptr++ (wraps
//     at DEPTH), fill <= min(fill+1, DEPTH-1); go IDLE.
// - Latency: strobe seen at edge k -> data_out/out_valid updated at edge k+2.
//   A strobe arriving in RD or CALC is dropped. Sample period must be >= 3 sysclk.
// - Arithmetic (signed):
//   e = (fill >= d_reg && gain_reg != 0) ? (rd_data >>> gain_reg) : 0
//   s = x_reg + e, in W+1 bits; y = saturate s to [-2**(W-1), 2**(W-1)-1]
//   data_out <= y + DAC_OFFSET (mod 2**W); buffer word = mode_reg ? y : x_reg
// - Priming: echo stays 0 until d samples are written. If delay differs from d_reg at a strobe,
//   fill is cleared in that IDLE cycle, so no stale or misaligned echo plays after a change.
// - Max delay DEPTH-1; delay >= DEPTH is impossible by width.
// - Feedback with gain_shift >= 1 is stable (loop gain <= 1/2). Saturation bounds transients.
// - Mode/gain/delay are sampled only at strobe; changes between samples have no effect
//   until the next strobe.
// - Reset mid-operation (RD/CALC) aborts the sample: no RAM write, no out_valid pulse.
// TESTING
// 1 Reset: assert reset 2 cycles -> data_out='h200, out_valid=0. First sample 'h181 ->
//   data_out='h200, out_valid pulses once, 2 edges after strobe.
// 2 Single echo: mode=0, delay=4, gain_shift=1, impulse data_in='h181+100 then 'h181 ->
//   data_out: 'h200+100, then 'h200 x3, then 'h200+50 at sample 5, then 'h200.
// 3 Feedback: mode=1, delay=2, gain_shift=1, impulse +128 -> outputs +128,0,+64,0,+32,0,+16...
// 4 Saturation: mode=0, delay=1, gain_shift=1, constant x=+500 -> second sample 500+250
//   clamps to 511 -> data_out='h3FF (not wrapped). x=-512 -> clamps to 'h000.
// 5 Wrap/priming: AW=4, delay=15, drive 40 samples -> echo first at sample 16, correct
//   across wr_ptr wrap. Change delay to 3 -> next 3 outputs echo-free, then echo resumes.
// 6 Handshake: data_valid held high 10 cycles -> one out_valid. Second rising edge 2 cycles
//   after the first -> dropped, one out_valid. gain_shift=0 -> data_out = x+'h200 exactly.

Source files
------------

// File: rtl/echo_processor.sv
// rtl/echo_processor.sv - circular-buffer echo mixer between ADC input codes and DAC output codes
module echo_processor #(
    parameter int W = 10,
    parameter int AW = 13,
    parameter logic [W-1:0] ADC_OFFSET = W'('h181),
    parameter logic [W-1:0] DAC_OFFSET = W'('h200)
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic [W-1:0]  data_in,
    input  logic          data_valid,
    input  logic [AW-1:0] delay,
    input  logic [1:0]    gain_shift,
    input  logic          mode,
    output logic [W-1:0]  data_out,
    output logic          out_valid
);
    localparam int DEPTH = 2**AW;
    localparam logic signed [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] Y_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, CALC} state_t;
    state_t state, state_next;

    logic                 dv_q;
    logic                 strobe;
    logic                 start;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        fill;
    logic [AW-1:0]        d_eff;
    logic [AW-1:0]        d_reg;
    logic [AW-1:0]        rd_addr;
    logic [1:0]           gain_reg;
    logic                 mode_reg;
    logic signed [W-1:0]  x_reg;
    logic signed [W-1:0]  rd_data;
    logic signed [W-1:0]  shifted;
    logic signed [W-1:0]  echo;
    logic signed [W-1:0]  y;
    logic [W:0]           sum;
    logic [W-1:0]         mem [DEPTH];

    assign strobe  = data_valid & ~dv_q;
    assign start   = (state == IDLE) && strobe;
    assign d_eff   = (delay == '0) ? AW'(1) : delay;
    assign rd_addr = wr_ptr - d_eff;

    // Echo is masked until d_reg samples exist behind wr_ptr since the last clear.
    assign shifted = rd_data >>> gain_reg;
    assign echo    = (fill >= d_reg && gain_reg != 2'd0) ? shifted : '0;
    assign sum     = {x_reg[W-1], x_reg} + {echo[W-1], echo};

    always_comb begin
        y = sum[W-1:0];
        if (sum[W] != sum[W-1]) begin
            y = sum[W] ? Y_MIN : Y_MAX;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (strobe) state_next = RD;
            RD:      state_next = CALC;
            CALC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            dv_q      <= 1'b0;
            wr_ptr    <= '0;
            fill      <= '0;
            d_reg     <= AW'(1);
            gain_reg  <= 2'd0;
            mode_reg  <= 1'b0;
            x_reg     <= '0;
            data_out  <= DAC_OFFSET;
            out_valid <= 1'b0;
        end else begin
            dv_q      <= data_valid;
            out_valid <= 1'b0;
            if (start) begin
                x_reg    <= data_in - ADC_OFFSET;
                d_reg    <= d_eff;
                gain_reg <= gain_shift;
                mode_reg <= mode;
                if (d_eff != d_reg) begin
                    fill <= '0;
                end
            end
            if (state == CALC) begin
                data_out  <= y + DAC_OFFSET;
                out_valid <= 1'b1;
                wr_ptr    <= wr_ptr + AW'(1);
                fill      <= (&fill) ? fill : fill + AW'(1);
            end
        end
    end

    // Buffer RAM: never reset; a reset during RD/CALC suppresses the pending write.
    always_ff @(posedge sysclk) begin
        if (!reset && state == CALC) begin
            mem[wr_ptr] <= mode_reg ? y : x_reg;
        end
        if (start) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule
